sample_packetiser: RTL
======================

SAMPLE_PACKETISER -- requirements
Module: sample_packetiser

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 10: ADC sample width in bits, range 8..16.
REQ-002 Parameter OUT_WIDTH, default 16: output word width, SHALL be >= SAMPLE_WIDTH.
REQ-003 Parameter FIFO_DEPTH, default 32768: buffer depth in words, SHALL be a power of two.
REQ-004 Parameter PACKET_WORDS, default 8192: words per USB packet, SHALL be <= FIFO_DEPTH/2.
REQ-005 Parameter ERROR_MARGIN, default 64: free-word margin below which buffer_error asserts.
REQ-006 adc_clock  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 collect_data  in  1  capture enable.
REQ-009 read_data  in  1  read request from the downstream bus interface.
REQ-010 test_mode  in  2  source select: 0 ADC, 1 counter, 2 triangle, 3 checkerboard.
REQ-011 error_clear  in  1  single-cycle clear of the sticky error flags.
REQ-012 adc_data  in  SAMPLE_WIDTH  unsigned offset-binary ADC sample.
REQ-013 data_out  out  OUT_WIDTH  signed two's-complement sample.
REQ-014 data_valid  out  1  data_out holds a word popped on the previous cycle.
REQ-015 data_available  out  1  at least PACKET_WORDS words are buffered.
REQ-016 fifo_used  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-017 buffer_error  out  1  sticky overflow or near-full flag.
REQ-018 underflow_error  out  1  sticky read-while-empty flag.
REQ-019 packet_count  out  16  number of complete packets written since capture start; wraps at 65535 to 0.

Function
REQ-020 Source mux: mode 0 passes adc_data; mode 1 is an up-counter wrapping at 2^SAMPLE_WIDTH-1 to 0; mode 2 is a triangle that counts up to max, then down to 0, then repeats, with each endpoint emitted once; mode 3 alternates 0x2AA..., 0x155... (SAMPLE_WIDTH-bit alternating patterns).
REQ-021 Generators SHALL advance only on cycles where a word is written; they SHALL restart at 0 (triangle direction up) on every rising edge of collect_data.
REQ-022 Write occurs on every cycle with collect_data=1 and FIFO not full; the source sample is registered one cycle before the FIFO write (fixed 1-cycle input pipeline).
REQ-023 A write attempt while full SHALL be dropped and SHALL set buffer_error.
REQ-024 buffer_error SHALL also set when collect_data=1 and fifo_used > FIFO_DEPTH-ERROR_MARGIN.
REQ-025 A pop occurs on read_data=1 with FIFO not empty; data_out updates and data_valid=1 on the next cycle; otherwise data_valid=0 and data_out holds its value.
REQ-026 read_data=1 while empty SHALL set underflow_error and leave data_out unchanged.
REQ-027 Conversion: data_out = sign-extend(sample XOR MSB-mask); i.e. 0 maps to -2^(SAMPLE_WIDTH-1) and 2^(SAMPLE_WIDTH-1) maps to 0.
REQ-028 A simultaneous write and pop SHALL leave fifo_used unchanged; at full, a simultaneous write and pop SHALL succeed without an error.
REQ-029 data_available = (fifo_used >= PACKET_WORDS), combinational from registered occupancy.
REQ-030 A packet word counter increments per write; on reaching PACKET_WORDS it returns to 0 and packet_count increments.
REQ-031 The rising edge of collect_data SHALL flush the FIFO, zero the packet word counter and packet_count, and clear both error flags.
REQ-032 Sticky errors clear only on error_clear, a rising edge of collect_data, or reset; a set condition coincident with error_clear SHALL win.
REQ-033 Capture state machine: IDLE (no writes) -> ARM on collect_data rise (one flush cycle) -> CAPTURE -> IDLE on collect_data=0; reads are allowed in every state except ARM.

Reset
REQ-034 Reset SHALL put the FSM in IDLE, empty the FIFO, and drive data_out=0, data_valid=0, data_available=0, fifo_used=0, buffer_error=0, underflow_error=0, packet_count=0, and generators to 0.
REQ-035 Reset asserted mid-capture SHALL discard all buffered words; FIFO RAM contents need no reset.

Structure
REQ-036 Package sample_pkg SHALL hold the test_mode encodings, the FSM state enumeration and the checkerboard constants.
REQ-037 Sub-module sample_fifo_sc (single-clock FIFO with an occupancy output, inferred RAM) SHALL be instantiated once; the source mux, conversion and flags live in the top.

Verification
REQ-038 Mode 1, collect 8192 cycles, no reads -> data_available rises on the cycle fifo_used reaches 8192; packet_count=1.
REQ-039 Mode 1, drain the FIFO -> data_out sequence -512, -511, ..., 511, -512 (wrap) with SAMPLE_WIDTH=10.
REQ-040 Mode 0, adc_data=0x200 then 0x000 -> data_out 0x0000 then 0xFE00.
REQ-041 FIFO_DEPTH=64, ERROR_MARGIN=4, collect with no reads -> buffer_error=1 when fifo_used=61, remains set after collect_data falls, cleared by error_clear.
REQ-042 read_data=1 on an empty FIFO -> underflow_error=1, data_valid=0; reset pulse mid-capture -> all outputs 0 on the next edge.
REQ-043 Mode 2, SAMPLE_WIDTH=8 -> raw sequence 0..255, 254..0, 1..., each peak emitted exactly once.

Source files
------------

// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - shared encodings and constants for the sample packetiser
package sample_pkg;

  // Source select encodings carried on test_mode
  typedef enum logic [1:0] {
    MODE_ADC      = 2'd0,
    MODE_COUNTER  = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_CHECKER  = 2'd3
  } test_mode_t;

  // Capture sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } cap_state_t;

  // Checkerboard patterns; the low SAMPLE_WIDTH bits are used
  localparam logic [15:0] CHECKER_A = 16'hAAAA;
  localparam logic [15:0] CHECKER_B = 16'h5555;

endpackage

// File: rtl/sample_fifo_sc.sv
// rtl/sample_fifo_sc.sv - single-clock FIFO with occupancy output and flush
module sample_fifo_sc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32768
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   used,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (used == UW'(DEPTH));
  assign empty = (used == '0);

  // RAM write port; contents are never reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Registered read port; the register doubles as the held output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_ptr];
  end

  // Pointers and occupancy; flush drops all buffered words at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   used <= used + UW'(1);
        2'b01:   used <= used - UW'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/sample_packetiser.sv
// rtl/sample_packetiser.sv - ADC/test-pattern capture into a packet FIFO
module sample_packetiser
  import sample_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 10,
  parameter int OUT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 32768,
  parameter int PACKET_WORDS = 8192,
  parameter int ERROR_MARGIN = 64
) (
  input  logic                          adc_clock,
  input  logic                          reset,
  input  logic                          collect_data,
  input  logic                          read_data,
  input  logic [1:0]                    test_mode,
  input  logic                          error_clear,
  input  logic [SAMPLE_WIDTH-1:0]       adc_data,
  output logic [OUT_WIDTH-1:0]          data_out,
  output logic                          data_valid,
  output logic                          data_available,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
  output logic                          buffer_error,
  output logic                          underflow_error,
  output logic [15:0]                   packet_count
);

  localparam int UW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PWW = $clog2(PACKET_WORDS) + 1;
  localparam logic [UW-1:0]           PKT_LEVEL = UW'(PACKET_WORDS);
  localparam logic [UW-1:0]           ERR_LEVEL = UW'(FIFO_DEPTH - ERROR_MARGIN);
  localparam logic [PWW-1:0]          PKT_LAST  = PWW'(PACKET_WORDS - 1);
  localparam logic [SAMPLE_WIDTH-1:0] SMAX      = '1;
  localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK  = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
  localparam logic [SAMPLE_WIDTH-1:0] CHK_A     = CHECKER_A[SAMPLE_WIDTH-1:0];
  localparam logic [SAMPLE_WIDTH-1:0] CHK_B     = CHECKER_B[SAMPLE_WIDTH-1:0];

  cap_state_t              state;
  logic                    collect_q;
  logic                    collect_rise;
  logic                    reads_allowed;
  logic                    load;
  logic [SAMPLE_WIDTH-1:0] gen_count;
  logic [SAMPLE_WIDTH-1:0] tri_val;
  logic                    tri_down;
  logic                    chk_phase;
  logic [SAMPLE_WIDTH-1:0] src;
  logic [SAMPLE_WIDTH-1:0] src_q;
  logic                    pipe_valid;
  logic [SAMPLE_WIDTH-1:0] flipped;
  logic [OUT_WIDTH-1:0]    wr_word;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    wr_ok;
  logic                    rd_ok;
  logic                    overflow;
  logic                    near_full;
  logic                    underflow;
  logic [UW-1:0]           used_next;
  logic [PWW-1:0]          word_cnt;

  // A capture start flushes everything; nothing is read during that cycle or the ARM cycle
  assign collect_rise  = collect_data && !collect_q;
  assign reads_allowed = (state != ST_ARM) && !collect_rise;
  assign load          = collect_data && ((state == ST_ARM) || (state == ST_CAPTURE));

  assign rd_ok     = read_data && reads_allowed && !fifo_empty;
  assign underflow = read_data && reads_allowed && fifo_empty;
  assign wr_ok     = pipe_valid && !collect_rise && (!fifo_full || rd_ok);
  assign overflow  = pipe_valid && !collect_rise && fifo_full && !rd_ok;
  assign used_next = fifo_used + UW'(wr_ok) - UW'(rd_ok);
  assign near_full = collect_data && (used_next > ERR_LEVEL);

  // Offset binary to two's complement: flip the MSB, then sign-extend
  assign flipped        = src_q ^ MSB_MASK;
  assign wr_word        = OUT_WIDTH'($signed(flipped));
  assign data_available = (fifo_used >= PKT_LEVEL);

  // Source select between the ADC and the three test generators
  always_comb begin
    src = adc_data;
    case (test_mode_t'(test_mode))
      MODE_ADC:      src = adc_data;
      MODE_COUNTER:  src = gen_count;
      MODE_TRIANGLE: src = tri_val;
      MODE_CHECKER:  src = chk_phase ? CHK_B : CHK_A;
      default:       src = adc_data;
    endcase
  end

  // Capture state machine: IDLE -> ARM (flush) -> CAPTURE -> IDLE
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      collect_q <= 1'b0;
    end else begin
      collect_q <= collect_data;
      case (state)
        ST_IDLE:    if (collect_rise) state <= ST_ARM;
        ST_ARM:     state <= collect_data ? ST_CAPTURE : ST_IDLE;
        ST_CAPTURE: if (!collect_data) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Generators step together on every sample taken so switching modes stays phase-aligned
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      gen_count <= '0;
      tri_val   <= '0;
      tri_down  <= 1'b0;
      chk_phase <= 1'b0;
    end else if (collect_rise) begin
      gen_count <= '0;
      tri_val   <= '0;
      tri_down  <= 1'b0;
      chk_phase <= 1'b0;
    end else if (load) begin
      gen_count <= gen_count + SAMPLE_WIDTH'(1);
      chk_phase <= !chk_phase;
      if (!tri_down) begin
        if (tri_val == SMAX) begin
          tri_down <= 1'b1;
          tri_val  <= SMAX - SAMPLE_WIDTH'(1);
        end else begin
          tri_val  <= tri_val + SAMPLE_WIDTH'(1);
        end
      end else if (tri_val == '0) begin
        tri_down <= 1'b0;
        tri_val  <= SAMPLE_WIDTH'(1);
      end else begin
        tri_val  <= tri_val - SAMPLE_WIDTH'(1);
      end
    end
  end

  // One-cycle input pipeline ahead of the FIFO write
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      src_q      <= '0;
      pipe_valid <= 1'b0;
    end else begin
      pipe_valid <= load;
      if (load) src_q <= src;
    end
  end

  // Sticky error flags; a new set condition beats error_clear
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      buffer_error    <= 1'b0;
      underflow_error <= 1'b0;
    end else if (collect_rise) begin
      buffer_error    <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      buffer_error    <= (buffer_error && !error_clear) || overflow || near_full;
      underflow_error <= (underflow_error && !error_clear) || underflow;
    end
  end

  // Packet framing: count accepted words, bump packet_count per full packet
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) begin
      word_cnt     <= '0;
      packet_count <= '0;
    end else if (collect_rise) begin
      word_cnt     <= '0;
      packet_count <= '0;
    end else if (wr_ok) begin
      if (word_cnt == PKT_LAST) begin
        word_cnt     <= '0;
        packet_count <= packet_count + 16'd1;
      end else begin
        word_cnt     <= word_cnt + PWW'(1);
      end
    end
  end

  // data_valid marks the cycle after a pop
  always_ff @(posedge adc_clock or posedge reset) begin
    if (reset) data_valid <= 1'b0;
    else       data_valid <= rd_ok;
  end

  sample_fifo_sc #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (adc_clock),
    .rst     (reset),
    .flush   (collect_rise),
    .wr_en   (wr_ok),
    .wr_data (wr_word),
    .rd_en   (rd_ok),
    .rd_data (data_out),
    .used    (fifo_used),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
